// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response channel between the CPU load/store path and dmem_ctrl.
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_memop[2:0]       000 b, 001 h, 010 w, 100 bu, 101 hu
//   req_addr[31:0]       byte address
//   req_wdata[31:0]      right-aligned store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata[31:0]      extended load data (0 for stores and errors)
//   rsp_err              request rejected, no memory side effect
// master = requester (CPU side), slave = dmem_ctrl.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_memop, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_memop, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-clock data-memory controller with a synchronous word RAM.
// Accepts one load/store at a time, steers byte lanes, sign/zero-extends loads
// and rejects illegal memops, out-of-range addresses and (unless split support
// is built in) misaligned accesses.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dmem_ctrl_if.slave request/response channel
// Build option: define DMEM_SPLIT_EN to run word-crossing accesses as two RAM
// accesses (lower word, then upper word with wrap to word 0).
module dmem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
`ifdef DMEM_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, DATA, RESP} state_t;

    state_t             state, state_d;
    logic               req_ready_q;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    // Request fields latched at accept
    logic               we_q, err_q, split_q;
    logic [2:0]         memop_q;
    logic [1:0]         off_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         wmask_q;
    logic [63:0]        wdata_q;
    logic [31:0]        lo_q;

    // Request decode, evaluated on the request as presented
    logic               accept;
    logic [1:0]         size_c, off_c;
    logic               illegal_c, range_err_c, misaligned_c, crossing_c, req_err_c;
    logic [3:0]         size_mask_c;

    assign accept       = bus.req_valid && req_ready_q;
    assign size_c       = bus.req_memop[1:0];
    assign off_c        = bus.req_addr[1:0];
    assign illegal_c    = (size_c == 2'b11) || (bus.req_memop == 3'b110);
    assign range_err_c  = (bus.req_addr >> ADDR_W) != 32'd0;
    assign misaligned_c = ((size_c == 2'b01) && off_c[0]) || ((size_c == 2'b10) && (off_c != 2'd0));
    assign crossing_c   = ((size_c == 2'b01) && (off_c == 2'd3)) || ((size_c == 2'b10) && (off_c != 2'd0));
    assign req_err_c    = illegal_c || range_err_c || (misaligned_c && !SPLIT_EN);
    assign size_mask_c  = (size_c == 2'b00) ? 4'b0001 : (size_c == 2'b01) ? 4'b0011 : 4'b1111;

    // RAM port: ACC0 addresses the lower word, ACC1 the next word (wrapping)
    logic [31:0]        mem [DEPTH];
    logic [31:0]        ram_q;
    logic               ram_en, ram_we;
    logic [IDX_W-1:0]   ram_idx;
    logic [3:0]         ram_lanes;
    logic [31:0]        ram_wdata;

    assign ram_en    = (state == ACC0) || (state == ACC1);
    assign ram_we    = ram_en && we_q && !err_q;
    assign ram_idx   = (state == ACC1) ? idx_q + IDX_W'(1) : idx_q;
    assign ram_lanes = (state == ACC1) ? wmask_q[7:4] : wmask_q[3:0];
    assign ram_wdata = (state == ACC1) ? wdata_q[63:32] : wdata_q[31:0];

    // Synchronous word RAM with byte-lane write enables
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we && ram_lanes[0]) mem[ram_idx][7:0]   <= ram_wdata[7:0];
            if (ram_we && ram_lanes[1]) mem[ram_idx][15:8]  <= ram_wdata[15:8];
            if (ram_we && ram_lanes[2]) mem[ram_idx][23:16] <= ram_wdata[23:16];
            if (ram_we && ram_lanes[3]) mem[ram_idx][31:24] <= ram_wdata[31:24];
            ram_q <= mem[ram_idx];
        end
    end

    // Load assembly: lower word comes from lo_q when the access was split
    logic [31:0] lo_word, shifted, load_data;
    logic        sext;

    assign lo_word = split_q ? lo_q : ram_q;
    assign shifted = 32'({ram_q, lo_word} >> {off_q, 3'b000});
    assign sext    = !memop_q[2];

    always_comb begin
        load_data = shifted;
        case (memop_q[1:0])
            2'b00:   load_data = {{24{sext && shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sext && shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Next-state and registered-output values
    always_comb begin
        state_d     = state;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state)
            IDLE: if (accept) state_d = ACC0;
            ACC0: begin
                if (split_q) begin
                    state_d = ACC1;
                end else if (we_q || err_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = 32'd0;
                end else begin
                    state_d = DATA;
                end
            end
            ACC1: begin
                if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = load_data;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; req_ready tracks the IDLE state one edge ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state       <= state_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request capture and split lower-word hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            memop_q <= 3'd0;
            off_q   <= 2'd0;
            idx_q   <= '0;
            wmask_q <= 8'd0;
            wdata_q <= 64'd0;
            lo_q    <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                err_q   <= req_err_c;
                split_q <= SPLIT_EN && crossing_c && !req_err_c;
                memop_q <= bus.req_memop;
                off_q   <= off_c;
                idx_q   <= bus.req_addr[ADDR_W-1:2];
                wmask_q <= {4'b0000, size_mask_c} << off_c;
                wdata_q <= {32'd0, bus.req_wdata} << {off_c, 3'b000};
            end
            if (state == ACC1) lo_q <= ram_q;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, handshaked data-memory controller for the CPU load/store path. It replaces the fixed two-clock data memory with a single-clock block that owns a synchronous word RAM. Requests arrive on a valid/ready channel and responses leave on a valid/ready channel. It performs byte-lane steering, sign/zero extension and range/encoding checks, and optionally splits misaligned word-crossing accesses.

## Interface
- ADDR_W, 17: decoded byte-address bits; RAM depth is 2^(ADDR_W-2) 32-bit words
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected; no memory side effect

## Operation
- Accept: req_valid && req_ready on a rising edge; request fields latched; one request in flight max.
- req_ready = 1 only in IDLE and only while rst_n high.
- States: IDLE, ACC0, ACC1, DATA, RESP.
  - IDLE -> ACC0 on accept.
  - ACC0 -> ACC1 if split. Otherwise -> DATA for a load, -> RESP for a store or error.
  - ACC1 -> DATA for a load, -> RESP for a store.
  - DATA -> RESP.
  - RESP -> IDLE when rsp_ready.
- Error, checked at accept:
  - illegal memop (011, 110, 111), for either req_we value;
  - req_addr[31:ADDR_W] != 0;
  - misaligned access when split is not compiled in.
  - On error: no RAM write, rsp_err=1, rsp_rdata=0.
- Store lanes: size mask (b=0001, h=0011, w=1111) and wdata are shifted left by addr[1:0] bytes. Lanes shifted past bit 31 go to word+1 (split only).
- Load: the addressed bytes are extracted from the RAM word(s). Memop 000/001 sign-extends; 100/101 zero-extends. A store with a bu/hu memop is legal and writes byte/half.
- Word index = addr[ADDR_W-1:2]. A split second access uses (index+1) mod depth, wrapping from the top word to word 0.
- RAM writes occur only in ACC0/ACC1. The RAM read port is read-enabled only in ACC0/ACC1.

## Timing
- Reset values (while rst_n low): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
- rsp_valid is registered. It rises L edges after the accepting edge:
  - error: L=1
  - aligned/non-crossing store: L=1
  - aligned/non-crossing load: L=2
  - split store: L=2
  - split load: L=3
- rsp_valid, rsp_rdata and rsp_err hold stable until the edge where rsp_ready=1. rsp_valid then drops and req_ready rises the same cycle.
- Back-to-back throughput: with rsp_ready tied 1, an aligned load every 4 cycles and a store every 3.
- No read/write hazard: the next request cannot be accepted before the prior write completes.
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared. A split store may leave its ACC0 lanes written and its ACC1 lanes unwritten.

## Configuration
- DMEM_SPLIT_EN defined:
  - A half at offset 1 and a word at offset 0 run in one access.
  - A half at offset 3 and words at offsets 1, 2 and 3 cross a word boundary and run as ACC0 (lower word) then ACC1 (upper word).
  - The load result is assembled from both words.
- DMEM_SPLIT_EN undefined:
  - Any half with addr[0]=1, or word with addr[1:0]!=0, is an error (rsp_err=1, L=1).
  - ACC1 is unreachable.

## Test plan
- Store w 0x11223344 @0x100, then lb @0x103 -> rsp_rdata 0x00000011. lh @0x102 -> 0x00001122. lw @0x100 -> 0x11223344 at L=2.
- Store b 0x80 @0x201, then lb @0x201 -> 0xFFFFFF80, lbu @0x201 -> 0x00000080. Bytes 0x200/0x202/0x203 unchanged.
- memop 011 @0x0 -> rsp_err=1 at L=1 with no write. Store to 0x00020000 (ADDR_W=17) -> rsp_err=1, and RAM word 0 is unchanged.
- Hold rsp_ready=0 for 5 cycles after a load: outputs stable, req_ready=0, and a second req_valid is not accepted until one cycle of rsp_ready=1.
- With DMEM_SPLIT_EN: store w 0xAABBCCDD @0x1FFFF wraps, with byte 0x1FFFF=DD and bytes 0x0..0x2 = CC,BB,AA. lw @0x1FFFF -> 0xAABBCCDD at L=3. Without DMEM_SPLIT_EN: the same store -> rsp_err=1.
- Assert rst_n low during DATA of a load: rsp_valid stays 0, req_ready=0 during reset and 1 the cycle after release. A following lw returns correct data.
